// File: rtl/hex_disp_pkg.sv
// Shared constants and helpers for the multi-digit 7-segment display controller:
// the active-low glyph table, the blank pattern and a per-digit BCD increment.
package hex_disp_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs, entry n = hex digit n (F listed first).
    localparam logic [15:0][SEG_W-1:0] GLYPH_TBL = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Returns {carry_out, digit_out}; codes 9..F roll to 0 and carry.
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] digit, input logic carry_in);
        if (!carry_in) begin
            return {1'b0, digit};
        end else if (digit <= 4'd8) begin
            return {1'b0, digit + 4'd1};
        end else begin
            return {1'b1, 4'd0};
        end
    endfunction

endpackage

// File: rtl/hex_glyph_dec.sv
// Combinational nibble-to-glyph decoder with a dark override; one per digit.
module hex_glyph_dec
    import hex_disp_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic             dark,
    output logic [SEG_W-1:0] glyph_n
);

    assign glyph_n = dark ? SEG_BLANK : GLYPH_TBL[nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex/BCD display register with registered active-low segment drive,
// blanking and blinking. Define HEX_DISPLAY_LZB_EN to add leading-zero blanking (lzb).
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                        CLOCK_50,
    input  logic                        RESET,
    input  logic                        load,
    input  logic [4*NUM_DIGITS-1:0]     value,
    input  logic                        clr,
    input  logic                        inc,
    input  logic                        bcd_mode,
    input  logic [NUM_DIGITS-1:0]       blank_mask,
    input  logic [NUM_DIGITS-1:0]       blink_mask,
`ifdef HEX_DISPLAY_LZB_EN
    input  logic                        lzb,
`endif
    output logic [SEG_W*NUM_DIGITS-1:0] seg,
    output logic [4*NUM_DIGITS-1:0]     disp_value,
    output logic                        ovf
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [DW-1:0]               disp_q, disp_d;
    logic                        ovf_q, ovf_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        phase_q, phase_d;
    logic [SEG_W*NUM_DIGITS-1:0] seg_q, seg_d;
    logic [NUM_DIGITS-1:0]       lzb_dark, dark;
    logic [DW:0]                 hex_sum;
    logic [4:0]                  bcd_step;
    logic                        bcd_carry;

    always_comb begin
        disp_d    = disp_q;
        ovf_d     = 1'b0;
        hex_sum   = {1'b0, disp_q} + (DW + 1)'(1);
        bcd_step  = '0;
        bcd_carry = 1'b1;
        if (clr) begin
            disp_d = '0;
        end else if (load) begin
            disp_d = value;
        end else if (inc) begin
            if (bcd_mode) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    bcd_step             = bcd_digit_inc(disp_q[4*i +: 4], bcd_carry);
                    disp_d[4*i +: 4]     = bcd_step[3:0];
                    bcd_carry            = bcd_step[4];
                end
                ovf_d = bcd_carry;
            end else begin
                disp_d = hex_sum[DW-1:0];
                ovf_d  = hex_sum[DW];
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

`ifdef HEX_DISPLAY_LZB_EN
    logic zero_above;

    // Digit 0 is never suppressed, so a zero register still shows one "0".
    always_comb begin
        lzb_dark   = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above  = zero_above & (disp_q[4*i +: 4] == 4'h0);
            lzb_dark[i] = lzb & zero_above;
        end
    end
`else
    assign lzb_dark = '0;
`endif

    assign dark = blank_mask | (blink_mask & {NUM_DIGITS{phase_q}}) | lzb_dark;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        hex_glyph_dec u_dec (
            .nibble  (disp_q[4*g +: 4]),
            .dark    (dark[g]),
            .glyph_n (seg_d[SEG_W*g +: SEG_W])
        );
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            seg_q   <= '1;
        end else begin
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
        end
    end

    assign seg        = seg_q;
    assign disp_value = disp_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl (4 digits, BLINK_DIV = 4).
module tb_hex_display_ctrl;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load, clr, inc, bcd_mode;
    logic [15:0]   value;
    logic [3:0]    blank_mask, blink_mask;
    logic [27:0]   seg;
    logic [15:0]   disp_value;
    logic          ovf;
`ifdef HEX_DISPLAY_LZB_EN
    logic          lzb;
`endif

    int total = 0;
    int bad   = 0;

    // Hand-inverted glyphs from the segment table, index = hex digit.
    logic [6:0] exp_glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(4)) dut (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .load       (load),
        .value      (value),
        .clr        (clr),
        .inc        (inc),
        .bcd_mode   (bcd_mode),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
`ifdef HEX_DISPLAY_LZB_EN
        .lzb        (lzb),
`endif
        .seg        (seg),
        .disp_value (disp_value),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] glyphs(input logic [15:0] v);
        logic [27:0] r;
        for (int i = 0; i < ND; i++) r[7*i +: 7] = exp_glyph[v[4*i +: 4]];
        return r;
    endfunction

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; value = v;
        tick();
        load = 1'b0;
    endtask

    task automatic do_inc();
        inc = 1'b1;
        tick();
        inc = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b1; clr = 1'b0; inc = 1'b0; bcd_mode = 1'b0;
        value = 16'h1234; blank_mask = '0; blink_mask = '0;
`ifdef HEX_DISPLAY_LZB_EN
        lzb = 1'b0;
`endif
        tick(); tick();
        check("rst_disp", 32'(disp_value), 32'h0);
        check("rst_seg",  32'(seg), 32'h0FFF_FFFF);
        check("rst_ovf",  32'(ovf), 32'h0);
        rst = 1'b0; load = 1'b0;
        tick(); tick();
        check("rst_zero_seg", 32'(seg), 32'(28'h810_2040));

        // Decode: all sixteen glyphs over four loads.
        foreach (exp_glyph[k]) begin end
        begin
            logic [15:0] pats [4] = '{16'hBA98, 16'hFEDC, 16'h3210, 16'h7654};
            for (int p = 0; p < 4; p++) begin
                do_load(pats[p]);
                check("dec_disp", 32'(disp_value), 32'(pats[p]));
                tick();
                check("dec_seg", 32'(seg), 32'(glyphs(pats[p])));
            end
        end
        do_load(16'h000B);
        tick();
        check("dec_b", 32'(seg[6:0]), 32'h03);
        do_load(16'h000D);
        tick();
        check("dec_d", 32'(seg[6:0]), 32'h21);

        // Hex increment and wrap.
        do_load(16'h00FF);
        do_inc();
        check("hex_carry", 32'(disp_value), 32'h0100);
        check("hex_carry_ovf", 32'(ovf), 32'h0);
        do_load(16'hFFFF);
        check("hex_pre_ovf", 32'(ovf), 32'h0);
        do_inc();
        check("hex_wrap", 32'(disp_value), 32'h0);
        check("hex_wrap_ovf", 32'(ovf), 32'h1);
        tick();
        check("hex_ovf_one", 32'(ovf), 32'h0);

        // BCD increment.
        bcd_mode = 1'b1;
        do_load(16'h0999);
        do_inc();
        check("bcd_ripple", 32'(disp_value), 32'h1000);
        check("bcd_ripple_ovf", 32'(ovf), 32'h0);
        do_load(16'h000A);
        do_inc();
        check("bcd_a_digit", 32'(disp_value), 32'h0010);
        do_load(16'h9999);
        do_inc();
        check("bcd_wrap", 32'(disp_value), 32'h0);
        check("bcd_wrap_ovf", 32'(ovf), 32'h1);
        tick();
        check("bcd_ovf_one", 32'(ovf), 32'h0);
        bcd_mode = 1'b0;

        // Command priority.
        do_load(16'hFFFF);
        clr = 1'b1; load = 1'b1; inc = 1'b1; value = 16'h1234;
        tick();
        clr = 1'b0; load = 1'b0; inc = 1'b0;
        check("prio_clr", 32'(disp_value), 32'h0);
        check("prio_clr_ovf", 32'(ovf), 32'h0);
        load = 1'b1; inc = 1'b1; value = 16'h0005;
        tick();
        load = 1'b0; inc = 1'b0;
        check("prio_load", 32'(disp_value), 32'h0005);

        // Blink: restart the prescaler with reset, digit 0 blinking.
        rst = 1'b1; blink_mask = 4'b0001;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            logic [27:0] e;
            tick();
            e = 28'h810_2040;
            if (((k - 1) / 4) % 2 == 1) e[6:0] = 7'h7F;
            check("blink", 32'(seg), 32'(e));
        end
        blank_mask = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("blank", 32'(seg), 32'(28'h810_207F));
        end
        blank_mask = '0; blink_mask = '0;

`ifdef HEX_DISPLAY_LZB_EN
        lzb = 1'b1;
        do_load(16'h0042);
        tick();
        check("lzb_42", 32'(seg), 32'({7'h7F, 7'h7F, 7'h19, 7'h24}));
        do_load(16'h0000);
        tick();
        check("lzb_zero", 32'(seg), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
        lzb = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
